// File: rtl/my_iabc_polar.sv
// Phase currents (ia, ib) to polar vector (phase, magnitude): Clarke transform
// followed by a sequential vectoring-mode CORDIC, one conversion per start strobe.
module my_iabc_polar #(
    parameter int ITER = 16,
    parameter int W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ia_i,
    input  logic [15:0] ib_i,
    output logic        busy,
    output logic        valid,
    output logic [15:0] ph_o,
    output logic [15:0] mag_o
);

    localparam int IW = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLARKE,
        S_PREROT,
        S_ITER,
        S_SCALE
    } state_t;

    state_t                state_q, state_d;
    logic signed [15:0]    ia_q, ia_d;
    logic signed [15:0]    ib_q, ib_d;
    logic signed [W-1:0]   alpha_q, alpha_d;
    logic signed [W-1:0]   beta_q, beta_d;
    logic signed [W-1:0]   x_q, x_d;
    logic signed [W-1:0]   y_q, y_d;
    logic [15:0]           z_q, z_d;
    logic [IW-1:0]         it_q, it_d;
    logic                  zero_q, zero_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [15:0]           ph_q, ph_d;
    logic [15:0]           mag_q, mag_d;

    logic signed [17:0]    sum18;
    logic signed [35:0]    beta_p;
    logic [W+15:0]         mag_p;
    logic [W-1:0]          mag_sh;
    logic signed [W-1:0]   xs, ys;

    function automatic logic [15:0] atan_lut(input logic [IW-1:0] i);
        logic [15:0] a;
        case (int'(i))
            0:       a = 16'd8192;
            1:       a = 16'd4836;
            2:       a = 16'd2555;
            3:       a = 16'd1297;
            4:       a = 16'd651;
            5:       a = 16'd326;
            6:       a = 16'd163;
            7:       a = 16'd81;
            8:       a = 16'd41;
            9:       a = 16'd20;
            10:      a = 16'd10;
            11:      a = 16'd5;
            12:      a = 16'd3;
            13:      a = 16'd1;
            14:      a = 16'd1;
            default: a = 16'd0;
        endcase
        return a;
    endfunction

    // beta = (ia + 2*ib) / sqrt(3), with 37837/65536 approximating 1/sqrt(3)
    assign sum18  = {{2{ia_q[15]}}, ia_q} + {ib_q[15], ib_q, 1'b0};
    assign beta_p = sum18 * 18'sd37837;
    assign mag_p  = {16'b0, x_q} * {{W{1'b0}}, 16'd39797};
    assign mag_sh = W'(mag_p >> 16);
    assign xs     = x_q >>> it_q;
    assign ys     = y_q >>> it_q;

    always_comb begin
        state_d = state_q;
        ia_d    = ia_q;
        ib_d    = ib_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        it_d    = it_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        ph_d    = ph_q;
        mag_d   = mag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ia_d    = ia_i;
                    ib_d    = ib_i;
                    state_d = S_CLARKE;
                end
            end
            S_CLARKE: begin
                alpha_d = W'(ia_q);
                beta_d  = W'(beta_p >>> 16);
                state_d = S_PREROT;
            end
            S_PREROT: begin
                // Fold the left half-plane onto the right so CORDIC converges
                if (alpha_q < 0) begin
                    x_d = -alpha_q;
                    y_d = -beta_q;
                    z_d = 16'h8000;
                end else begin
                    x_d = alpha_q;
                    y_d = beta_q;
                    z_d = '0;
                end
                zero_d  = (alpha_q == '0) && (beta_q == '0);
                it_d    = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!y_q[W-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_lut(it_q);
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_lut(it_q);
                end
                it_d = it_q + 1'b1;
                if (it_q == IW'(ITER - 1)) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                if (zero_q) begin
                    ph_d  = '0;
                    mag_d = '0;
                end else begin
                    ph_d  = z_q;
                    mag_d = (|mag_sh[W-1:15]) ? 16'h7FFF : mag_sh[15:0];
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ia_q    <= '0;
            ib_q    <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            it_q    <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ph_q    <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            ia_q    <= ia_d;
            ib_q    <= ib_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            it_q    <= it_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ph_q    <= ph_d;
            mag_q   <= mag_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign ph_o  = ph_q;
    assign mag_o = mag_q;

endmodule
